// File: rtl/led_blinker_pkg.sv
// Shared types and width helpers for the LED blinker.
// Retrigger mode is selected by the LED_BLINKER_RETRIG_EN macro in led_blinker.sv.
package led_blinker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_st_t;

    function automatic int pend_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    // A one-bit counter is the floor so that ON_CLKS=OFF_CLKS=1 still elaborates.
    function automatic int timer_width(input int on_clks, input int off_clks);
        int m;
        m = (on_clks > off_clks) ? on_clks : off_clks;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/led_blinker_if.sv
// Event-in / LED-out signal bundle of the blinker; slave is the blinker side.
interface led_blinker_if
    import led_blinker_pkg::*;
#(
    parameter int MAX_PENDING = 15
) ();

    localparam int PW = pend_width(MAX_PENDING);

    logic          event_i;
    logic          led_o;
    logic          busy_o;
    logic [PW-1:0] pending_o;
    logic          overflow_o;

    modport slave (
        input  event_i,
        output led_o,
        output busy_o,
        output pending_o,
        output overflow_o
    );

    modport master (
        output event_i,
        input  led_o,
        input  busy_o,
        input  pending_o,
        input  overflow_o
    );

endinterface

// File: rtl/led_blinker_blink_timer.sv
// Loadable down-counter shared by the ON and OFF phases; holds at zero.
module blink_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/led_blinker.sv
// Turns event pulses into ON_CLKS-high / OFF_CLKS-low blinks with a saturating event queue.
// Define LED_BLINKER_RETRIG_EN to make events during ON extend the current blink instead of queueing.
module led_blinker
    import led_blinker_pkg::*;
#(
    parameter int ON_CLKS     = 1000,
    parameter int OFF_CLKS    = 1000,
    parameter int MAX_PENDING = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    led_blinker_if.slave  bus
);

    localparam int PW = pend_width(MAX_PENDING);
    localparam int TW = timer_width(ON_CLKS, OFF_CLKS);

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CLKS - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CLKS - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    blink_st_t     state_q, state_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          led_q, led_d;
    logic          ovf_q, ovf_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_zero;
    logic          enq;
    logic          deq;
    logic          retrig_hit;

    blink_timer #(
        .W (TW)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            led_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.event_i || (pending_q != '0)) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (retrig_hit) begin
                    state_d = ON;
                end else if (tmr_zero) begin
                    state_d = OFF;
                end
            end
            OFF: begin
                if (tmr_zero) begin
                    state_d = (pending_q != '0) ? ON : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An event arriving in IDLE starts the blink itself; a queued one is only
    // drawn down when no fresh event is available to start it.
    always_comb begin
        enq        = 1'b0;
        deq        = 1'b0;
        retrig_hit = 1'b0;
        case (state_q)
            IDLE: begin
                deq = !bus.event_i && (pending_q != '0);
            end
            ON: begin
`ifdef LED_BLINKER_RETRIG_EN
                retrig_hit = bus.event_i;
`else
                enq = bus.event_i;
`endif
            end
            OFF: begin
                enq = bus.event_i;
                deq = tmr_zero && (pending_q != '0);
            end
            default: begin
                enq = 1'b0;
            end
        endcase

        tmr_load  = ((state_d != state_q) && (state_d != IDLE)) || retrig_hit;
        tmr_value = (state_d == OFF) ? OFF_LOAD : ON_LOAD;

        pending_d = pending_q;
        ovf_d     = 1'b0;
        if (enq && !deq) begin
            if (pending_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (deq && !enq) begin
            pending_d = pending_q - 1'b1;
        end

        led_d = (state_d == ON);
    end

    assign bus.led_o      = led_q;
    assign bus.pending_o  = pending_q;
    assign bus.overflow_o = ovf_q;
    assign bus.busy_o     = (state_q != IDLE) || (pending_q != '0);

endmodule
